// File: rtl/rv32i_timer_pkg.sv
// Shared constants for the rv32i machine timer: halfword register map,
// CTRL bit positions and reset values.
package rv32i_timer_pkg;

    localparam logic [3:0] TIMER_MTIME0   = 4'd0;
    localparam logic [3:0] TIMER_MTIME1   = 4'd1;
    localparam logic [3:0] TIMER_MTIME2   = 4'd2;
    localparam logic [3:0] TIMER_MTIME3   = 4'd3;
    localparam logic [3:0] TIMER_CMP0     = 4'd4;
    localparam logic [3:0] TIMER_CMP1     = 4'd5;
    localparam logic [3:0] TIMER_CMP2     = 4'd6;
    localparam logic [3:0] TIMER_CMP3     = 4'd7;
    localparam logic [3:0] TIMER_CTRL     = 4'd8;
    localparam logic [3:0] TIMER_PRESCALE = 4'd9;
    localparam logic [3:0] TIMER_RELOAD0  = 4'd10;
    localparam logic [3:0] TIMER_RELOAD1  = 4'd11;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IRQ = 2;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rv32i_timer_prescaler.sv
// Prescaler for the machine timer: emits one tick every (compare_i + 1)
// enabled cycles; clear_i restarts the count.
module rv32i_timer_prescaler #(
    parameter int PRESCALE_BITS = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [PRESCALE_BITS-1:0] compare_i,
    output logic                     tick_o
);

    logic [PRESCALE_BITS-1:0] count;

    assign tick_o = enable_i && (count == compare_i);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count <= '0;
        end else if (tick_o) begin
            count <= '0;
        end else if (enable_i) begin
            count <= count + PRESCALE_BITS'(1);
        end
    end

endmodule

// File: rtl/rv32i_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp timer over a 16-bit halfword port.
// Define RV32I_TIMER_AUTORELOAD_EN to build the periodic RELOAD feature.
module rv32i_timer
    import rv32i_timer_pkg::*;
#(
    parameter int PORT_LEN      = 16,
    parameter int ADDR_BITS     = 4,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 write_i,
    input  logic                 read_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [PORT_LEN-1:0]  data_i,
    output logic [PORT_LEN-1:0]  data_o,
    output logic                 irq_o
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [47:0] staging_time;
    logic [47:0] staging_cmp;
    logic [47:0] shadow_time;
    logic [47:0] shadow_cmp;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PORT_LEN-1:0] rdata;
    logic [PORT_LEN-1:0] ctrl_word;
    logic [3:0] idx;
    logic enable;
    logic irq_pending;
    logic tick;
    logic wr_prescale;
    logic commit_time;
    logic commit_cmp;
    logic autoreload;
    logic [31:0] reload;
    logic reload_fire;

    assign idx         = 4'(addr_i);
    assign wr_prescale = write_i && (idx == TIMER_PRESCALE);
    assign commit_time = write_i && (idx == TIMER_MTIME3);
    assign commit_cmp  = write_i && (idx == TIMER_CMP3);
    assign irq_o       = irq_pending;

`ifdef RV32I_TIMER_AUTORELOAD_EN
    assign reload_fire = enable && autoreload && (reload != '0)
                         && (mtime >= mtimecmp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            autoreload <= 1'b0;
            reload     <= '0;
        end else if (write_i) begin
            if (idx == TIMER_CTRL)    autoreload    <= data_i[CTRL_AR];
            if (idx == TIMER_RELOAD0) reload[15:0]  <= data_i;
            if (idx == TIMER_RELOAD1) reload[31:16] <= data_i;
        end
    end
`else
    assign autoreload  = 1'b0;
    assign reload      = '0;
    assign reload_fire = 1'b0;
`endif

    rv32i_timer_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable),
        .clear_i  (wr_prescale),
        .compare_i(prescale),
        .tick_o   (tick)
    );

    always_comb begin
        ctrl_word           = '0;
        ctrl_word[CTRL_EN]  = enable;
        ctrl_word[CTRL_AR]  = autoreload;
        ctrl_word[CTRL_IRQ] = irq_pending;
    end

    // Upper halves come from the shadow captured by the index-0/4 read.
    always_comb begin
        rdata = '0;
        case (idx)
            TIMER_MTIME0:   rdata = mtime[15:0];
            TIMER_MTIME1:   rdata = shadow_time[15:0];
            TIMER_MTIME2:   rdata = shadow_time[31:16];
            TIMER_MTIME3:   rdata = shadow_time[47:32];
            TIMER_CMP0:     rdata = mtimecmp[15:0];
            TIMER_CMP1:     rdata = shadow_cmp[15:0];
            TIMER_CMP2:     rdata = shadow_cmp[31:16];
            TIMER_CMP3:     rdata = shadow_cmp[47:32];
            TIMER_CTRL:     rdata = ctrl_word;
            TIMER_PRESCALE: rdata = PORT_LEN'(prescale);
            TIMER_RELOAD0:  rdata = reload[15:0];
            TIMER_RELOAD1:  rdata = reload[31:16];
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mtime        <= '0;
            mtimecmp     <= MTIMECMP_RESET;
            staging_time <= '0;
            staging_cmp  <= '0;
            shadow_time  <= '0;
            shadow_cmp   <= '0;
            prescale     <= '0;
            enable       <= 1'b0;
            irq_pending  <= 1'b0;
            data_o       <= '0;
        end else begin
            if (read_i) begin
                data_o <= rdata;
                if (idx == TIMER_MTIME0) shadow_time <= mtime[63:16];
                if (idx == TIMER_CMP0)   shadow_cmp  <= mtimecmp[63:16];
            end

            irq_pending <= enable && (mtime >= mtimecmp);

            if (commit_time)  mtime <= {data_i, staging_time};
            else if (tick)    mtime <= mtime + 64'd1;

            if (commit_cmp)       mtimecmp <= {data_i, staging_cmp};
            else if (reload_fire) mtimecmp <= mtimecmp + {32'd0, reload};

            if (write_i) begin
                case (idx)
                    TIMER_MTIME0:   staging_time[15:0]  <= data_i;
                    TIMER_MTIME1:   staging_time[31:16] <= data_i;
                    TIMER_MTIME2:   staging_time[47:32] <= data_i;
                    TIMER_CMP0:     staging_cmp[15:0]   <= data_i;
                    TIMER_CMP1:     staging_cmp[31:16]  <= data_i;
                    TIMER_CMP2:     staging_cmp[47:32]  <= data_i;
                    TIMER_CTRL:     enable   <= data_i[CTRL_EN];
                    TIMER_PRESCALE: prescale <= data_i[PRESCALE_BITS-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_timer.sv
// Self-checking bench for rv32i_timer: directed scenarios plus randomized
// bus traffic compared against a behavioural timer model.
module tb_rv32i_timer;

`ifdef RV32I_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        write_i = 1'b0;
    logic        read_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [15:0] data_i = '0;
    logic [15:0] data_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_timer dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .write_i(write_i),
        .read_i (read_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_o  (irq_o)
    );

    // Behavioural model state
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_rel;
    logic [15:0] m_pre;
    int unsigned m_cnt;
    bit          m_en, m_ar, m_irq;
    logic [15:0] stg_t[3], stg_c[3];
    logic [47:0] sh_t, sh_c;
    logic [15:0] m_rd;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_time = 64'd0;
        m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_rel  = 32'd0;
        m_pre  = 16'd0;
        m_cnt  = 0;
        m_en   = 0;
        m_ar   = 0;
        m_irq  = 0;
        m_rd   = 16'd0;
        sh_t   = 48'd0;
        sh_c   = 48'd0;
        for (int i = 0; i < 3; i++) begin
            stg_t[i] = 16'd0;
            stg_c[i] = 16'd0;
        end
    endtask

    function automatic logic [15:0] model_read(int a);
        logic [15:0] v;
        v = 16'd0;
        case (a)
            0:  v = m_time[15:0];
            1:  v = sh_t[15:0];
            2:  v = sh_t[31:16];
            3:  v = sh_t[47:32];
            4:  v = m_cmp[15:0];
            5:  v = sh_c[15:0];
            6:  v = sh_c[31:16];
            7:  v = sh_c[47:32];
            8:  v = {13'd0, m_irq, m_ar, m_en};
            9:  v = m_pre;
            10: v = m_rel[15:0];
            11: v = m_rel[31:16];
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // One clock edge of the timer, computed from the pre-edge state.
    task automatic model_edge(bit w, bit r, int a, logic [15:0] d);
        logic [63:0] t, c;
        bit en, tick;
        t = m_time;
        c = m_cmp;
        en = m_en;
        tick = en && (m_cnt == m_pre);
        if (r) begin
            m_rd = model_read(a);
            if (a == 0) sh_t = t[63:16];
            if (a == 4) sh_c = c[63:16];
        end
        m_irq = en && (t >= c);
        if (w && a == 9) m_cnt = 0;
        else if (tick) m_cnt = 0;
        else if (en) m_cnt++;
        m_time = tick ? t + 64'd1 : t;
        if (m_ar && m_rel != 0 && en && t >= c) m_cmp = c + {32'd0, m_rel};
        if (w) begin
            case (a)
                0, 1, 2: stg_t[a] = d;
                3: m_time = {d, stg_t[2], stg_t[1], stg_t[0]};
                4, 5, 6: stg_c[a-4] = d;
                7: m_cmp = {d, stg_c[2], stg_c[1], stg_c[0]};
                8: begin
                    m_en = d[0];
                    if (AR) m_ar = d[1];
                end
                9: begin
                    m_pre = d;
                    m_cnt = 0;
                end
                10: if (AR) m_rel[15:0] = d;
                11: if (AR) m_rel[31:16] = d;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(bit rst, bit w, bit r, int a, logic [15:0] d);
        reset_i = rst;
        write_i = w;
        read_i  = r;
        addr_i  = 4'(a);
        data_i  = d;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(w, r, a, d);
        #1;
        check("data_o", {48'd0, data_o}, {48'd0, m_rd});
        check("irq_o", {63'd0, irq_o}, {63'd0, m_irq});
        reset_i = 0;
        write_i = 0;
        read_i  = 0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0, 16'd0);
    endtask

    task automatic wr(int a, logic [15:0] d);
        cycle(0, 1, 0, a, d);
    endtask

    task automatic rd(int a);
        cycle(0, 0, 1, a, 16'd0);
    endtask

    logic [63:0] acc;
    logic [15:0] exp16;
    int rises, highs, budget;
    bit prev_irq;
    int ra;
    bit rw, rr, rrst;
    logic [15:0] rdat;

    initial begin
        // Reset state
        cycle(1, 0, 0, 0, 16'd0);
        check("rst_irq", {63'd0, irq_o}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            rd(i);
            exp16 = (i >= 4 && i < 8) ? 16'hFFFF : 16'h0000;
            check("rst_read", {48'd0, data_o}, {48'd0, exp16});
        end

        // Prescale 3: one tick per 4 cycles
        wr(9, 16'd3);
        wr(8, 16'd1);
        idle(40);
        rd(0);
        check("pre_40", {48'd0, data_o}, 64'd10);
        idle(3);
        rd(0);
        check("pre_44", {48'd0, data_o}, 64'd11);

        // Wrap across bit 32 and shadowed upper halves
        cycle(1, 0, 0, 0, 16'd0);
        wr(0, 16'hFFFE);
        wr(1, 16'hFFFF);
        wr(2, 16'h0000);
        wr(3, 16'h0000);
        wr(8, 16'd1);
        idle(3);
        rd(0);
        acc[15:0] = data_o;
        rd(1);
        acc[31:16] = data_o;
        rd(2);
        acc[47:32] = data_o;
        rd(3);
        acc[63:48] = data_o;
        check("atomic_read", acc, 64'h0000_0001_0000_0001);

        // irq rises one cycle after mtime reaches mtimecmp
        cycle(1, 0, 0, 0, 16'd0);
        wr(4, 16'd20);
        wr(5, 16'd0);
        wr(6, 16'd0);
        wr(7, 16'd0);
        wr(8, 16'd1);
        for (int i = 1; i <= 21; i++) begin
            idle(1);
            check("irq_rise", {63'd0, irq_o}, (i == 21) ? 64'd1 : 64'd0);
        end
        wr(4, 16'd100);
        wr(5, 16'd0);
        wr(6, 16'd0);
        wr(7, 16'd0);
        check("irq_hold", {63'd0, irq_o}, 64'd1);
        idle(1);
        check("irq_drop", {63'd0, irq_o}, 64'd0);

        // Partial write leaves mtimecmp untouched until commit
        wr(4, 16'd5);
        idle(2);
        check("partial_irq", {63'd0, irq_o}, 64'd0);
        rd(4);
        check("partial_cmp", {48'd0, data_o}, 64'd100);
        wr(5, 16'd0);
        wr(6, 16'd0);
        wr(7, 16'd0);
        idle(1);
        check("commit_irq", {63'd0, irq_o}, 64'd1);
        rd(4);
        check("commit_cmp", {48'd0, data_o}, 64'd5);

`ifdef RV32I_TIMER_AUTORELOAD_EN
        // Periodic irq via autoreload
        cycle(1, 0, 0, 0, 16'd0);
        wr(10, 16'd8);
        wr(11, 16'd0);
        wr(4, 16'd8);
        wr(5, 16'd0);
        wr(6, 16'd0);
        wr(7, 16'd0);
        wr(8, 16'd3);
        rises = 0;
        highs = 0;
        prev_irq = 0;
        budget = 0;
        while (!(rises == 3 && !irq_o) && budget < 200) begin
            idle(1);
            if (irq_o && !prev_irq) rises++;
            if (irq_o) highs++;
            prev_irq = irq_o;
            budget++;
        end
        check("ar_timeout", {32'd0, 32'(budget)} < 64'd200, 64'd1);
        check("ar_rises", 64'(rises), 64'd3);
        check("ar_highs", 64'(highs), 64'd3);
        rd(4);
        check("ar_cmp", {48'd0, data_o}, 64'd32);
`endif

        // Randomized traffic against the model
        cycle(1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 3000; i++) begin
            ra   = int'($urandom_range(0, 15));
            rw   = ($urandom_range(0, 2) == 0);
            rr   = ($urandom_range(0, 1) == 0);
            rrst = ($urandom_range(0, 499) == 0);
            rdat = 16'($urandom);
            case (ra)
                0, 4:  rdat = 16'($urandom_range(0, 300));
                1, 2, 3, 5, 6, 7:
                    if ($urandom_range(0, 3) != 0) rdat = 16'd0;
                8:     rdat = 16'($urandom_range(0, 7));
                9:     rdat = 16'($urandom_range(0, 3));
                10:    rdat = 16'($urandom_range(0, 40));
                11:    if ($urandom_range(0, 3) != 0) rdat = 16'd0;
                default: ;
            endcase
            cycle(rrst, rw, rr, ra, rdat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
